hh_neuron_scheduler: RTL and testbench

HH_NEURON_SCHEDULER -- requirements
Module: hh_neuron_scheduler

---
 rtl/hh_neuron_scheduler_pkg.sv | 17 +
 rtl/hh_neuron_scheduler_update.sv | 26 ++
 rtl/hh_neuron_scheduler.sv | 122 ++++++++++++
 tb/tb_hh_neuron_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hh_neuron_scheduler_pkg.sv
// hh_neuron_scheduler_pkg: shared FSM state type, config address map and default sizes
// Contents:
//   state_t          - scheduler FSM states
//   CFG_ADDR_THRESH  - cfg_addr value that targets the threshold register
//   DW_DEF           - default membrane/stimulus width
//   N_NEURONS_DEF    - default number of time-multiplexed neurons
package hh_neuron_scheduler_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;
    localparam logic [2:0] CFG_ADDR_THRESH = 3'd4;
    localparam int DW_DEF        = 8;
    localparam int N_NEURONS_DEF = 4;
endpackage

// File: rtl/hh_neuron_scheduler_update.sv
// hh_update: combinational leaky-integrate membrane update shared by all neurons
// Ports:
//   i_v       - current membrane value
//   i_stim    - stimulus of the neuron being updated
//   i_thresh  - spike threshold
//   o_v_store - value to write back (0 after a spike)
//   o_spike   - saturated next value reached the threshold
module hh_update
    import hh_neuron_scheduler_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_v,
    input  logic [DW-1:0] i_stim,
    input  logic [DW-1:0] i_thresh,
    output logic [DW-1:0] o_v_store,
    output logic          o_spike
);
    logic [DW+1:0] w_sum;
    logic [DW-1:0] w_v_next;
    // v - v/8 never goes negative, so two guard bits cover the carry of the stimulus term
    assign w_sum     = {2'b00, i_v} + {4'b0000, i_stim[DW-1:2]} - {5'b00000, i_v[DW-1:3]};
    assign w_v_next  = |w_sum[DW+1:DW] ? {DW{1'b1}} : w_sum[DW-1:0];
    assign o_spike   = w_v_next >= i_thresh;
    assign o_v_store = o_spike ? '0 : w_v_next;
endmodule

// File: rtl/hh_neuron_scheduler.sv
// hh_neuron_scheduler: time-multiplexed neuron sweep scheduler with spike handshake
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   i_tick             - pulse requesting a sweep over all neurons
//   i_cfg_we/addr/data - config write: addr 0..N-1 = stim[i], addr 4 = threshold
//   i_rd_addr/o_rd_data- combinational membrane readback
//   o_spike_valid/id   - spike event, held until i_spike_ready
//   o_busy             - sweep in progress
//   o_sweep_done       - one-cycle pulse at sweep end
//   o_tick_missed      - sticky flag: a tick arrived with one already pending
module hh_neuron_scheduler
    import hh_neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS  = N_NEURONS_DEF,
    parameter int DW         = DW_DEF,
    parameter int THRESH_RST = 150,
    localparam int IW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_tick,
    input  logic          i_cfg_we,
    input  logic [2:0]    i_cfg_addr,
    input  logic [DW-1:0] i_cfg_data,
    input  logic [IW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_spike_valid,
    input  logic          i_spike_ready,
    output logic [IW-1:0] o_spike_id,
    output logic          o_busy,
    output logic          o_sweep_done,
    output logic          o_tick_missed
);
    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic          r_pend;
    logic          r_missed;
    logic [DW-1:0] r_thr;
    logic [DW-1:0] r_v    [N_NEURONS];
    logic [DW-1:0] r_stim [N_NEURONS];
    logic [DW-1:0] w_v_store;
    logic          w_spike;
    logic          w_last;

    hh_update #(.DW(DW)) u_update (
        .i_v       (r_v[r_idx]),
        .i_stim    (r_stim[r_idx]),
        .i_thresh  (r_thr),
        .o_v_store (w_v_store),
        .o_spike   (w_spike)
    );

    assign w_last        = r_idx == IW'(N_NEURONS - 1);
    assign o_busy        = r_state != S_IDLE;
    assign o_spike_valid = r_state == S_EMIT;
    assign o_sweep_done  = r_state == S_DONE;
    assign o_spike_id    = r_idx;
    assign o_tick_missed = r_missed;
    assign o_rd_data     = r_v[i_rd_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_pend   <= 1'b0;
            r_missed <= 1'b0;
            r_thr    <= DW'(THRESH_RST);
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i]    <= '0;
                r_stim[i] <= '0;
            end
        end else begin
            if (i_cfg_we && i_cfg_addr == CFG_ADDR_THRESH)
                r_thr <= i_cfg_data;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (i_cfg_we && i_cfg_addr == 3'(i) && i != int'(CFG_ADDR_THRESH))
                    r_stim[i] <= i_cfg_data;
                if (r_state == S_RUN && r_idx == IW'(i))
                    r_v[i] <= w_v_store;
            end
            if (i_tick && o_busy) begin
                r_pend <= 1'b1;
                if (r_pend)
                    r_missed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    // pend can only be set here by a tick that landed on the DONE cycle
                    if (i_tick || r_pend) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_spike)
                        r_state <= S_EMIT;
                    else if (w_last)
                        r_state <= S_DONE;
                    else
                        r_idx <= r_idx + IW'(1);
                end
                S_EMIT: begin
                    if (i_spike_ready) begin
                        if (w_last)
                            r_state <= S_DONE;
                        else begin
                            r_state <= S_RUN;
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // the pending request is consumed; a tick on this cycle becomes the new one
                    r_state <= r_pend ? S_RUN : S_IDLE;
                    r_idx   <= '0;
                    r_pend  <= i_tick;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// tb_hh_neuron_scheduler: directed and randomized checks against a sweep-level reference model
module tb_hh_neuron_scheduler;
    localparam int N = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       spike_valid;
    logic       spike_ready = 1'b0;
    logic [1:0] spike_id;
    logic       busy;
    logic       sweep_done;
    logic       tick_missed;
    int n_cmp = 0;
    int n_bad = 0;
    int m_v [N];
    int m_stim [N];
    int m_thr;
    int v1_seq [6] = '{63, 119, 168, 210, 247, 0};

    hh_neuron_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tick        (tick),
        .i_cfg_we      (cfg_we),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_data    (cfg_data),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_spike_valid (spike_valid),
        .i_spike_ready (spike_ready),
        .o_spike_id    (spike_id),
        .o_busy        (busy),
        .o_sweep_done  (sweep_done),
        .o_tick_missed (tick_missed)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int v, input int s);
        int n;
        n = v + s / 4 - v / 8;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 1'b0;
        cfg_we = 1'b0;
        spike_ready = 1'b0;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_valid", spike_valid, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_id", spike_id, 0);
        chk("rst_missed", tick_missed, 0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_stim[i] = 0;
        end
        m_thr = 150;
    endtask

    task automatic cfg(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = 8'(data);
        cyc();
        cfg_we = 1'b0;
        if (addr == 4) m_thr = data;
        else if (addr < N) m_stim[addr] = data;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            #1;
            chk($sformatf("%s_v%0d", tag, i), rd_data, 32'(m_v[i]));
        end
    endtask

    task automatic run_sweep(input int hold);
        int nv;
        bit sp;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("run_busy", busy, 1);
            nv = model_next(m_v[i], m_stim[i]);
            sp = nv >= m_thr;
            m_v[i] = sp ? 0 : nv;
            cyc();
            if (sp) begin
                chk("emit_valid", spike_valid, 1);
                chk("emit_id", spike_id, 32'(i));
                rd_addr = 2'(i);
                #1;
                chk("emit_v_cleared", rd_data, 0);
                for (int h = 0; h < hold; h++) begin
                    cyc();
                    rd_addr = 2'((i + 1) % N);
                    #1;
                    chk("hold_valid", spike_valid, 1);
                    chk("hold_id", spike_id, 32'(i));
                    chk("hold_busy", busy, 1);
                    chk("hold_next_v", rd_data, 32'(m_v[(i + 1) % N]));
                end
                spike_ready = 1'b1;
                cyc();
                spike_ready = 1'b0;
            end else if (i < N - 1) begin
                chk("run_no_spike", spike_valid, 0);
            end
        end
        chk("sweep_done", sweep_done, 1);
        chk("done_no_valid", spike_valid, 0);
        cyc();
        chk("done_pulse_end", sweep_done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        cyc();
        do_reset();
        check_all("reset");
        cfg(5, 99);
        check_all("bad_addr");
        chk("bad_addr_busy", busy, 0);
        run_sweep(0);
        check_all("bad_addr_sweep");

        do_reset();
        cfg(0, 40);
        run_sweep(0);
        check_all("stim0");
        chk("stim0_v0", m_v[0], 10);

        do_reset();
        cfg(4, 20);
        cfg(2, 200);
        run_sweep(0);
        check_all("spike2");

        do_reset();
        cfg(4, 20);
        cfg(2, 200);
        run_sweep(3);
        check_all("spike2_hold");

        do_reset();
        cfg(4, 255);
        cfg(1, 255);
        for (int k = 0; k < 6; k++) begin
            run_sweep(0);
            rd_addr = 2'd1;
            #1;
            chk($sformatf("sat_seq%0d", k), rd_data, 32'(v1_seq[k]));
        end
        check_all("sat");

        do_reset();
        tick = 1'b1;
        cyc();
        cyc();
        cyc();
        tick = 1'b0;
        chk("missed_set", tick_missed, 1);
        cyc();
        cyc();
        chk("pend_done1", sweep_done, 1);
        cyc();
        chk("pend_rerun_busy", busy, 1);
        chk("pend_rerun_done", sweep_done, 0);
        for (int k = 0; k < 4; k++) cyc();
        chk("pend_done2", sweep_done, 1);
        cyc();
        chk("pend_idle", busy, 0);
        chk("missed_sticky", tick_missed, 1);
        rst_n = 1'b0;
        cyc();
        chk("missed_cleared", tick_missed, 0);
        rst_n = 1'b1;

        do_reset();
        cfg(4, 20);
        cfg(2, 200);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("pre_rst_valid", spike_valid, 1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid", spike_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_id", spike_id, 0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_stim[i] = 0;
        end
        m_thr = 150;
        check_all("midrst");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) cfg(i, int'($urandom_range(0, 255)));
            cfg(int'($urandom_range(5, 7)), int'($urandom_range(0, 255)));
            cfg(4, int'($urandom_range(30, 255)));
            run_sweep(int'($urandom_range(0, 3)));
            check_all($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
